// File: rtl/morse_pattern_tx.sv
// Timed MSB-first on/off pattern serializer with loop, gap and abort.
// Define MORSE_ROM_EN to source pattern/length from a SEL-indexed table.
module morse_pattern_tx #(
  parameter int TICK_DIV  = 25000000,
  parameter int PAT_W     = 16,
  parameter int LEN_W     = 5,
  parameter int GAP_UNITS = 3
) (
  input  logic             CLOCK_50,
  input  logic             RESETN,
  input  logic             START,
  input  logic             ABORT,
  input  logic             LOOP,
  input  logic [PAT_W-1:0] PATTERN,
  input  logic [LEN_W-1:0] LENGTH,
  input  logic [2:0]       SEL,
  output logic             OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [LEN_W-1:0] BIT_IDX
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
  localparam logic [LEN_W:0] PAT_W_L = (LEN_W+1)'(PAT_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   shift_q, shift_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic               out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [PAT_W-1:0]   req_pat;
  logic [LEN_W-1:0]   req_len;
  logic               unused_in;
  logic               tick;
  logic               last;

`ifdef MORSE_ROM_EN
  always_comb begin
    req_pat = '0;
    req_len = '0;
    unique case (SEL)
      3'd0: begin
        req_pat = {10'b1101101011, {(PAT_W-10){1'b0}}};
        req_len = LEN_W'(10);
      end
      3'd1: begin
        req_pat = {6'b101101, {(PAT_W-6){1'b0}}};
        req_len = LEN_W'(6);
      end
      3'd2: begin
        req_pat = {5'b10101, {(PAT_W-5){1'b0}}};
        req_len = LEN_W'(5);
      end
      3'd3: begin
        req_pat = {2'b11, {(PAT_W-2){1'b0}}};
        req_len = LEN_W'(2);
      end
      3'd4: begin
        req_pat = {6'b101011, {(PAT_W-6){1'b0}}};
        req_len = LEN_W'(6);
      end
      3'd5: begin
        req_pat = {8'b10101011, {(PAT_W-8){1'b0}}};
        req_len = LEN_W'(8);
      end
      3'd6: begin
        req_pat = {7'b1011011, {(PAT_W-7){1'b0}}};
        req_len = LEN_W'(7);
      end
      3'd7: begin
        req_pat = {9'b110101011, {(PAT_W-9){1'b0}}};
        req_len = LEN_W'(9);
      end
      default: ;
    endcase
  end
  assign unused_in = ^{PATTERN, LENGTH};
`else
  assign req_pat = PATTERN;
  assign req_len = ({1'b0, LENGTH} > PAT_W_L)
                 ? LEN_W'(PAT_W) : LENGTH;
  assign unused_in = ^SEL;
`endif

  assign tick = (cnt_q == CNT_W'(TICK_DIV-1));
  assign last = (idx_q == len_q - 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    gap_d   = gap_q;
    pat_d   = pat_q;
    shift_d = shift_q;
    len_d   = len_q;
    idx_d   = idx_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (ABORT) begin
      state_d = S_IDLE;
      out_d   = 1'b0;
      busy_d  = 1'b0;
      idx_d   = '0;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (START && req_len != '0) begin
            state_d = S_SEND;
            pat_d   = req_pat;
            len_d   = req_len;
            shift_d = req_pat;
            out_d   = req_pat[PAT_W-1];
            busy_d  = 1'b1;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
        S_SEND: begin
          if (tick) begin
            if (!last) begin
              shift_d = shift_q << 1;
              out_d   = shift_q[PAT_W-2];
              idx_d   = idx_q + 1'b1;
            end else if (!LOOP) begin
              state_d = S_IDLE;
              out_d   = 1'b0;
              busy_d  = 1'b0;
              idx_d   = '0;
              done_d  = 1'b1;
            end else if (GAP_UNITS > 0) begin
              state_d = S_GAP;
              out_d   = 1'b0;
              idx_d   = '0;
              gap_d   = '0;
            end else begin
              shift_d = pat_q;
              out_d   = pat_q[PAT_W-1];
              idx_d   = '0;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (gap_q == GAP_W'(GAP_UNITS-1)) begin
              state_d = S_SEND;
              shift_d = pat_q;
              out_d   = pat_q[PAT_W-1];
              cnt_d   = '0;
              gap_d   = '0;
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      pat_q   <= '0;
      shift_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      pat_q   <= pat_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign OUT     = out_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign BIT_IDX = idx_q;

endmodule

// File: tb/tb_morse_pattern_tx.sv
// Bench for morse_pattern_tx: per-cycle expectations from a
// waveform model built out of the pattern, length and pass count.
module tb_morse_pattern_tx;

  localparam int TD  = 4;
  localparam int GAP = 3;

  logic        CLOCK_50 = 1'b0;
  logic        RESETN = 1'b1;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        LOOP = 1'b0;
  logic [15:0] PATTERN = '0;
  logic [4:0]  LENGTH = '0;
  logic [2:0]  SEL = '0;
  logic        OUT;
  logic        BUSY;
  logic        DONE;
  logic [4:0]  BIT_IDX;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit o;
    bit b;
    bit d;
    int i;
  } smp_t;

  smp_t expq[$];

  morse_pattern_tx #(
    .TICK_DIV(TD), .PAT_W(16), .LEN_W(5), .GAP_UNITS(GAP)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESETN(RESETN),
    .START(START), .ABORT(ABORT), .LOOP(LOOP),
    .PATTERN(PATTERN), .LENGTH(LENGTH), .SEL(SEL),
    .OUT(OUT), .BUSY(BUSY), .DONE(DONE),
    .BIT_IDX(BIT_IDX)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Expected samples, one per clock, starting with the cycle after START.
  task automatic build(input logic [15:0] pat, input int len,
                       input int np);
    int l;
    smp_t s;
    l = (len > 16) ? 16 : len;
    expq.delete();
    for (int p = 0; p < np; p++) begin
      for (int b = 0; b < l; b++)
        for (int t = 0; t < TD; t++) begin
          s.o = pat[15-b]; s.b = 1; s.d = 0; s.i = b;
          expq.push_back(s);
        end
      if (p < np - 1)
        for (int t = 0; t < GAP * TD; t++) begin
          s.o = 0; s.b = 1; s.d = 0; s.i = -1;
          expq.push_back(s);
        end
    end
    s.o = 0; s.b = 0; s.d = 1; s.i = 0;
    expq.push_back(s);
    s.d = 0;
    expq.push_back(s);
    expq.push_back(s);
  endtask

  task automatic do_start(input logic [15:0] p, input logic [4:0] l,
                          input logic [2:0] s);
    PATTERN = p;
    LENGTH = l;
    SEL = s;
    START = 1'b1;
    @(negedge CLOCK_50);
    START = 1'b0;
  endtask

  task automatic test_reset;
    #3 RESETN = 1'b0;
    #1;
    total++;
    if ({OUT, BUSY, DONE, BIT_IDX} !== 8'h00) begin
      bad++;
      $display("FAIL reset: got %b want 0",
               {OUT, BUSY, DONE, BIT_IDX});
    end
    @(negedge CLOCK_50);
    RESETN = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic test_oneshot;
    logic [15:0] p;
    int l;
    for (int n = 0; n < 9; n++) begin
      p = (n == 0) ? 16'hB400 : 16'($urandom);
      l = (n == 0) ? 6 : int'($urandom_range(1, 16));
      build(p, l, 1);
      do_start(p, 5'(l), 3'd0);
      for (int k = 0; k < expq.size(); k++) begin
        total++;
        if (OUT !== expq[k].o || BUSY !== expq[k].b ||
            DONE !== expq[k].d ||
            (expq[k].i >= 0 && BIT_IDX !== 5'(expq[k].i))) begin
          bad++;
          $display("FAIL oneshot n=%0d k=%0d: got %b%b%b/%0d want %b%b%b/%0d",
                   n, k, OUT, BUSY, DONE, BIT_IDX,
                   expq[k].o, expq[k].b, expq[k].d, expq[k].i);
        end
        @(negedge CLOCK_50);
      end
    end
  endtask

  task automatic test_loop;
    logic [15:0] p;
    int l, np, drop, pass;
    for (int n = 0; n < 6; n++) begin
      p = (n == 0) ? 16'hB400 : 16'($urandom);
      l = (n == 0) ? 6 : int'($urandom_range(1, 16));
      np = (n == 0) ? 2 : int'($urandom_range(1, 3));
      pass = l * TD + GAP * TD;
      drop = (n == 0) ? 40 :
             (np - 1) * pass + int'($urandom_range(0, l * TD - 1));
      build(p, l, np);
      LOOP = (np > 1);
      do_start(p, 5'(l), 3'd0);
      for (int k = 0; k < expq.size(); k++) begin
        total++;
        if (OUT !== expq[k].o || BUSY !== expq[k].b ||
            DONE !== expq[k].d ||
            (expq[k].i >= 0 && BIT_IDX !== 5'(expq[k].i))) begin
          bad++;
          $display("FAIL loop n=%0d k=%0d: got %b%b%b/%0d want %b%b%b/%0d",
                   n, k, OUT, BUSY, DONE, BIT_IDX,
                   expq[k].o, expq[k].b, expq[k].d, expq[k].i);
        end
        if (k == drop) LOOP = 1'b0;
        @(negedge CLOCK_50);
      end
      LOOP = 1'b0;
    end
  endtask

  task automatic test_abort;
    logic [15:0] p;
    int l, at;
    for (int n = 0; n < 5; n++) begin
      p = (n == 0) ? 16'hB400 : 16'($urandom);
      l = (n == 0) ? 6 : int'($urandom_range(1, 16));
      at = (n == 0) ? 9 : int'($urandom_range(0, l * TD - 1));
      LOOP = (n > 2);
      build(p, l, 1);
      do_start(p, 5'(l), 3'd0);
      for (int k = 0; k <= at; k++) begin
        total++;
        if (OUT !== expq[k].o || BUSY !== expq[k].b ||
            DONE !== 1'b0 || BIT_IDX !== 5'(expq[k].i)) begin
          bad++;
          $display("FAIL abort_pre n=%0d k=%0d: got %b%b%b/%0d want %b%b0/%0d",
                   n, k, OUT, BUSY, DONE, BIT_IDX,
                   expq[k].o, expq[k].b, expq[k].i);
        end
        if (k == at) ABORT = 1'b1;
        @(negedge CLOCK_50);
      end
      ABORT = 1'b0;
      LOOP = 1'b0;
      for (int k = 0; k < 8; k++) begin
        total++;
        if ({OUT, BUSY, DONE, BIT_IDX} !== 8'h00) begin
          bad++;
          $display("FAIL abort_post n=%0d k=%0d: got %b want 0",
                   n, k, {OUT, BUSY, DONE, BIT_IDX});
        end
        @(negedge CLOCK_50);
      end
    end
  endtask

  task automatic test_edge;
    logic [15:0] p;
    do_start(16'hFFFF, 5'd0, 3'd0);
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({OUT, BUSY, DONE} !== 3'b000) begin
        bad++;
        $display("FAIL len0 k=%0d: got %b want 000",
                 k, {OUT, BUSY, DONE});
      end
      @(negedge CLOCK_50);
    end
    p = 16'($urandom) | 16'h0001;
    build(p, 31, 1);
    do_start(p, 5'd31, 3'd0);
    for (int k = 0; k < expq.size(); k++) begin
      total++;
      if (OUT !== expq[k].o || BUSY !== expq[k].b ||
          DONE !== expq[k].d || BIT_IDX !== 5'(expq[k].i)) begin
        bad++;
        $display("FAIL len31 k=%0d: got %b%b%b/%0d want %b%b%b/%0d",
                 k, OUT, BUSY, DONE, BIT_IDX,
                 expq[k].o, expq[k].b, expq[k].d, expq[k].i);
      end
      @(negedge CLOCK_50);
    end
    build(16'hB400, 6, 1);
    do_start(16'hB400, 5'd6, 3'd0);
    for (int k = 0; k < expq.size(); k++) begin
      total++;
      if (OUT !== expq[k].o || BUSY !== expq[k].b ||
          DONE !== expq[k].d || BIT_IDX !== 5'(expq[k].i)) begin
        bad++;
        $display("FAIL busy_start k=%0d: got %b%b%b/%0d want %b%b%b/%0d",
                 k, OUT, BUSY, DONE, BIT_IDX,
                 expq[k].o, expq[k].b, expq[k].d, expq[k].i);
      end
      START = (k == 5 || k == 13);
      PATTERN = (k >= 5) ? 16'h4FFF : 16'hB400;
      LENGTH = (k >= 5) ? 5'd3 : 5'd6;
      @(negedge CLOCK_50);
    end
    START = 1'b0;
    ABORT = 1'b1;
    do_start(16'hFFFF, 5'd4, 3'd0);
    ABORT = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({OUT, BUSY, DONE, BIT_IDX} !== 8'h00) begin
        bad++;
        $display("FAIL start_abort k=%0d: got %b want 0",
                 k, {OUT, BUSY, DONE, BIT_IDX});
      end
      @(negedge CLOCK_50);
    end
  endtask

  task automatic test_reset_mid;
    do_start(16'hFFFF, 5'd8, 3'd0);
    repeat (6) @(negedge CLOCK_50);
    total++;
    if ({OUT, BUSY} !== 2'b11) begin
      bad++;
      $display("FAIL pre_reset: got %b want 11", {OUT, BUSY});
    end
    #2 RESETN = 1'b0;
    #1;
    total++;
    if ({OUT, BUSY, DONE, BIT_IDX} !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset: got %b want 0",
               {OUT, BUSY, DONE, BIT_IDX});
    end
    @(negedge CLOCK_50);
    RESETN = 1'b1;
    @(negedge CLOCK_50);
    build(16'hB400, 6, 1);
    do_start(16'hB400, 5'd6, 3'd0);
    for (int k = 0; k < expq.size(); k++) begin
      total++;
      if (OUT !== expq[k].o || BUSY !== expq[k].b ||
          DONE !== expq[k].d || BIT_IDX !== 5'(expq[k].i)) begin
        bad++;
        $display("FAIL post_reset k=%0d: got %b%b%b/%0d want %b%b%b/%0d",
                 k, OUT, BUSY, DONE, BIT_IDX,
                 expq[k].o, expq[k].b, expq[k].d, expq[k].i);
      end
      @(negedge CLOCK_50);
    end
  endtask

`ifdef MORSE_ROM_EN
  task automatic test_rom;
    for (int n = 0; n < 2; n++) begin
      if (n == 0) build(16'hC000, 2, 1);
      else build(16'b1101101011000000, 10, 1);
      do_start(16'h0000, 5'd0, (n == 0) ? 3'd3 : 3'd0);
      for (int k = 0; k < expq.size(); k++) begin
        total++;
        if (OUT !== expq[k].o || BUSY !== expq[k].b ||
            DONE !== expq[k].d || BIT_IDX !== 5'(expq[k].i)) begin
          bad++;
          $display("FAIL rom n=%0d k=%0d: got %b%b%b/%0d want %b%b%b/%0d",
                   n, k, OUT, BUSY, DONE, BIT_IDX,
                   expq[k].o, expq[k].b, expq[k].d, expq[k].i);
        end
        @(negedge CLOCK_50);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef MORSE_ROM_EN
    test_rom();
`else
    test_oneshot();
    test_loop();
    test_abort();
    test_edge();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
